obi_rule_demux: RTL and testbench

Parametrised single-manager OBI demultiplexer with a run-time programmable address map, built-in error subordinate and outstanding-transaction tracking. It sits between one OBI manager port (core data, debug SBA or user-domain manager) and `NumSbr` subordinate ports. It replaces compile-time-only address rules with rules that software or a control block can reprogram. Responses always return in order: the block never switches target while responses are pending.

---
 rtl/obi_rule_demux.sv | 179 +++++++++++++++++
 tb/tb_obi_rule_demux.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_rule_demux.sv
// obi_rule_demux
// Single-manager OBI demultiplexer with a run-time programmable address map.
// Subordinate index 0 is an internal error subordinate. It grants at once and
// answers one cycle later with err=1 and rdata=0xBADCAB1E.
// Responses stay in order because the target is only switched once nothing is
// outstanding.
// Optional feature: define OBI_RULE_DEMUX_STATS_EN to build a saturating
// counter of error-subordinate responses on err_cnt_o. When the macro is not
// defined, err_cnt_o is tied to 0.
module obi_rule_demux #(
    parameter int NumSbr    = 5,
    parameter int NumRules  = 4,
    parameter int MaxTrans  = 4,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 1,
    parameter int IdxW      = $clog2(NumSbr)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumRules*AddrWidth-1:0] rule_start_i,
    input  logic [NumRules*AddrWidth-1:0] rule_end_i,
    input  logic [NumRules*IdxW-1:0]      rule_idx_i,
    input  logic [NumRules-1:0]           rule_en_i,
    input  logic                          mgr_req_i,
    output logic                          mgr_gnt_o,
    input  logic [AddrWidth-1:0]          mgr_addr_i,
    input  logic                          mgr_we_i,
    input  logic [DataWidth/8-1:0]        mgr_be_i,
    input  logic [DataWidth-1:0]          mgr_wdata_i,
    input  logic [IdWidth-1:0]            mgr_aid_i,
    output logic                          mgr_rvalid_o,
    output logic [DataWidth-1:0]          mgr_rdata_o,
    output logic [IdWidth-1:0]            mgr_rid_o,
    output logic                          mgr_err_o,
    output logic [NumSbr-1:0]             sbr_req_o,
    input  logic [NumSbr-1:0]             sbr_gnt_i,
    output logic [AddrWidth-1:0]          sbr_addr_o,
    output logic                          sbr_we_o,
    output logic [DataWidth/8-1:0]        sbr_be_o,
    output logic [DataWidth-1:0]          sbr_wdata_o,
    output logic [IdWidth-1:0]            sbr_aid_o,
    input  logic [NumSbr-1:0]             sbr_rvalid_i,
    input  logic [NumSbr*DataWidth-1:0]   sbr_rdata_i,
    input  logic [NumSbr*IdWidth-1:0]     sbr_rid_i,
    input  logic [NumSbr-1:0]             sbr_err_i,
    output logic [31:0]                   err_cnt_o
);

    localparam int                   CntW    = $clog2(MaxTrans + 1);
    localparam logic [CntW-1:0]      MaxCnt  = CntW'(MaxTrans);
    localparam logic [DataWidth-1:0] ErrData = DataWidth'(32'hBADCAB1E);

    logic [CntW-1:0]    r_cnt;
    logic [IdxW-1:0]    r_tgt;
    logic               r_err_pend;
    logic [IdWidth-1:0] r_err_aid;

    logic               w_hit;
    logic [IdxW-1:0]    w_rule_idx;
    logic [IdxW-1:0]    w_sel;
    logic               w_stall;
    logic               w_hs;
    logic               w_unused;

    // Index 0 of every subordinate-side input belongs to the internal error subordinate.
    assign w_unused = ^{sbr_gnt_i[0], sbr_rvalid_i[0], sbr_rdata_i[DataWidth-1:0],
                        sbr_rid_i[IdWidth-1:0], sbr_err_i[0]};

    assign sbr_addr_o  = mgr_addr_i;
    assign sbr_we_o    = mgr_we_i;
    assign sbr_be_o    = mgr_be_i;
    assign sbr_wdata_o = mgr_wdata_i;
    assign sbr_aid_o   = mgr_aid_i;

    // Address decode: the lowest-numbered enabled rule with start <= addr < end wins.
    always_comb begin
        w_hit      = 1'b0;
        w_rule_idx = '0;
        for (int r = 0; r < NumRules; r++) begin
            if (!w_hit && rule_en_i[r]
                && (mgr_addr_i >= rule_start_i[r*AddrWidth +: AddrWidth])
                && (mgr_addr_i <  rule_end_i[r*AddrWidth +: AddrWidth])) begin
                w_hit      = 1'b1;
                w_rule_idx = rule_idx_i[r*IdxW +: IdxW];
            end
        end
        // An out-of-range target index falls back to the error subordinate.
        w_sel = (w_hit && (32'(w_rule_idx) < NumSbr)) ? w_rule_idx : '0;
    end

    // Hold off new requests when the tracker is full or the target would change.
    assign w_stall = (r_cnt == MaxCnt) || ((r_cnt != '0) && (w_sel != r_tgt));

    // Request routing and grant return for the selected subordinate.
    always_comb begin
        sbr_req_o = '0;
        mgr_gnt_o = 1'b0;
        if (!w_stall) begin
            if (w_sel == '0) begin
                mgr_gnt_o = mgr_req_i;
            end else begin
                for (int i = 1; i < NumSbr; i++) begin
                    if (w_sel == IdxW'(i)) begin
                        sbr_req_o[i] = mgr_req_i;
                        mgr_gnt_o    = sbr_gnt_i[i];
                    end
                end
            end
        end
    end

    assign w_hs = mgr_req_i & mgr_gnt_o;

    // Response mux from the registered target; other subordinates are ignored.
    always_comb begin
        mgr_rvalid_o = 1'b0;
        mgr_rdata_o  = '0;
        mgr_rid_o    = '0;
        mgr_err_o    = 1'b0;
        if (r_tgt == '0) begin
            mgr_rvalid_o = r_err_pend;
            mgr_rdata_o  = ErrData;
            mgr_rid_o    = r_err_aid;
            mgr_err_o    = 1'b1;
        end else begin
            for (int i = 1; i < NumSbr; i++) begin
                if (r_tgt == IdxW'(i)) begin
                    // Nothing outstanding means a stray rvalid must not underflow the count.
                    mgr_rvalid_o = sbr_rvalid_i[i] && (r_cnt != '0);
                    mgr_rdata_o  = sbr_rdata_i[i*DataWidth +: DataWidth];
                    mgr_rid_o    = sbr_rid_i[i*IdWidth +: IdWidth];
                    mgr_err_o    = sbr_err_i[i];
                end
            end
        end
    end

    // Outstanding-transaction tracking, target capture and error-subordinate pipeline.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_tgt      <= '0;
            r_err_pend <= 1'b0;
            r_err_aid  <= '0;
        end else begin
            if (w_hs) begin
                r_tgt <= w_sel;
            end
            case ({w_hs, mgr_rvalid_o})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
            r_err_pend <= w_hs && (w_sel == '0);
            if (w_hs && (w_sel == '0)) begin
                r_err_aid <= mgr_aid_i;
            end
        end
    end

`ifdef OBI_RULE_DEMUX_STATS_EN
    logic [31:0] r_err_cnt;

    // Saturating count of responses delivered by the error subordinate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
        end else if (r_err_pend && (r_err_cnt != 32'hFFFF_FFFF)) begin
            r_err_cnt <= r_err_cnt + 32'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_obi_rule_demux.sv
// Testbench for obi_rule_demux: decode table, directed multi-cycle sequences
// and a randomized run against a queue-based transaction model.
module tb_obi_rule_demux;

    localparam int NumSbr = 5, NumRules = 4, MaxTrans = 4;
    localparam int AW = 32, DW = 32, IW = 1, IdxW = 3;
`ifdef OBI_RULE_DEMUX_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NumRules*AW-1:0] rule_start, rule_end;
    logic [NumRules*IdxW-1:0] rule_idx;
    logic [NumRules-1:0]    rule_en;
    logic                   mgr_req, mgr_gnt, mgr_we;
    logic [AW-1:0]          mgr_addr;
    logic [DW/8-1:0]        mgr_be;
    logic [DW-1:0]          mgr_wdata;
    logic [IW-1:0]          mgr_aid;
    logic                   mgr_rvalid, mgr_err;
    logic [DW-1:0]          mgr_rdata;
    logic [IW-1:0]          mgr_rid;
    logic [NumSbr-1:0]      sbr_req, sbr_gnt, sbr_rvalid, sbr_err;
    logic [AW-1:0]          sbr_addr;
    logic                   sbr_we;
    logic [DW/8-1:0]        sbr_be;
    logic [DW-1:0]          sbr_wdata;
    logic [IW-1:0]          sbr_aid;
    logic [NumSbr*DW-1:0]   sbr_rdata;
    logic [NumSbr*IW-1:0]   sbr_rid;
    logic [31:0]            err_cnt;

    obi_rule_demux #(
        .NumSbr(NumSbr), .NumRules(NumRules), .MaxTrans(MaxTrans),
        .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .rule_start_i(rule_start), .rule_end_i(rule_end),
        .rule_idx_i(rule_idx), .rule_en_i(rule_en),
        .mgr_req_i(mgr_req), .mgr_gnt_o(mgr_gnt),
        .mgr_addr_i(mgr_addr), .mgr_we_i(mgr_we), .mgr_be_i(mgr_be),
        .mgr_wdata_i(mgr_wdata), .mgr_aid_i(mgr_aid),
        .mgr_rvalid_o(mgr_rvalid), .mgr_rdata_o(mgr_rdata),
        .mgr_rid_o(mgr_rid), .mgr_err_o(mgr_err),
        .sbr_req_o(sbr_req), .sbr_gnt_i(sbr_gnt),
        .sbr_addr_o(sbr_addr), .sbr_we_o(sbr_we), .sbr_be_o(sbr_be),
        .sbr_wdata_o(sbr_wdata), .sbr_aid_o(sbr_aid),
        .sbr_rvalid_i(sbr_rvalid), .sbr_rdata_i(sbr_rdata),
        .sbr_rid_i(sbr_rid), .sbr_err_i(sbr_err),
        .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Rule table as the bench sees it; packed onto the DUT ports by apply_rules.
    logic [31:0] m_start[NumRules];
    logic [31:0] m_end[NumRules];
    int          m_idx[NumRules];
    logic        m_en[NumRules];

    typedef struct {
        int   tgt;
        logic aid;
    } txn_t;
    txn_t q[$];

    typedef struct {
        logic [3:0]  en;
        logic [31:0] addr;
        logic        req;
        logic [4:0]  gnt;
        logic [4:0]  exp_req;
        logic        exp_gnt;
    } dec_vec_t;
    dec_vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply_rules();
        for (int r = 0; r < NumRules; r++) begin
            rule_start[r*AW +: AW]     = m_start[r];
            rule_end[r*AW +: AW]       = m_end[r];
            rule_idx[r*IdxW +: IdxW]   = IdxW'(m_idx[r]);
            rule_en[r]                 = m_en[r];
        end
    endtask

    task automatic set_rule(input int r, input logic [31:0] s, input logic [31:0] e,
                            input int idx, input logic en);
        m_start[r] = s; m_end[r] = e; m_idx[r] = idx; m_en[r] = en;
    endtask

    function automatic int model_sel(input logic [31:0] a);
        for (int r = 0; r < NumRules; r++)
            if (m_en[r] && a >= m_start[r] && a < m_end[r])
                return (m_idx[r] < NumSbr) ? m_idx[r] : 0;
        return 0;
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mgr_req = 1'b0;
        sbr_rvalid = '0;
        sbr_gnt = '0;
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    logic [31:0] a_pick;
    logic        pending;
    int          e_sel, hd, exp_err;
    logic        e_stall, e_gnt, e_rv;
    logic [4:0]  e_req;

    initial begin
        rst = 1'b1;
        mgr_req = 0; mgr_addr = '0; mgr_we = 0; mgr_be = '1; mgr_wdata = '0; mgr_aid = '0;
        sbr_gnt = '0; sbr_rvalid = '0; sbr_rdata = '0; sbr_rid = '0; sbr_err = '0;
        set_rule(0, 32'h1000_0000, 32'h1000_2000, 2, 1'b1);
        set_rule(1, 32'h1000_1000, 32'h1000_3000, 3, 1'b1);
        set_rule(2, 32'h2000_0000, 32'h2000_1000, 6, 1'b1);
        set_rule(3, 32'h3000_1000, 32'h3000_0000, 1, 1'b1);
        apply_rules();
        #2;
        // Reset state with an idle manager.
        chk("rst_sbr_req", sbr_req, 5'b0);
        chk("rst_gnt", mgr_gnt, 1'b0);
        chk("rst_rvalid", mgr_rvalid, 1'b0);
        chk("rst_err_cnt", err_cnt, 32'd0);

        // Decode table, applied while reset holds the tracker empty.
        tbl[0]  = '{4'hF, 32'h1000_0000, 1'b1, 5'b11110, 5'b00100, 1'b1};
        tbl[1]  = '{4'hF, 32'h1000_1FFC, 1'b1, 5'b11110, 5'b00100, 1'b1};
        tbl[2]  = '{4'hF, 32'h1000_2000, 1'b1, 5'b11110, 5'b01000, 1'b1};
        tbl[3]  = '{4'hF, 32'h1000_2FFF, 1'b1, 5'b11110, 5'b01000, 1'b1};
        tbl[4]  = '{4'hF, 32'h1000_3000, 1'b1, 5'b11110, 5'b00000, 1'b1};
        tbl[5]  = '{4'hF, 32'h0FFF_FFFF, 1'b1, 5'b11110, 5'b00000, 1'b1};
        tbl[6]  = '{4'hF, 32'h2000_0000, 1'b1, 5'b11110, 5'b00000, 1'b1};
        tbl[7]  = '{4'hF, 32'h3000_0800, 1'b1, 5'b11110, 5'b00000, 1'b1};
        tbl[8]  = '{4'hF, 32'h1000_0004, 1'b1, 5'b11011, 5'b00100, 1'b0};
        tbl[9]  = '{4'hF, 32'h1000_2004, 1'b1, 5'b00001, 5'b01000, 1'b0};
        tbl[10] = '{4'hF, 32'h1000_0000, 1'b0, 5'b00000, 5'b00000, 1'b0};
        tbl[11] = '{4'hE, 32'h1000_1FFC, 1'b1, 5'b11110, 5'b01000, 1'b1};
        tbl[12] = '{4'h0, 32'h1000_1FFC, 1'b1, 5'b11110, 5'b00000, 1'b1};
        tbl[13] = '{4'hE, 32'h1000_0FFF, 1'b1, 5'b11110, 5'b00000, 1'b1};
        for (int i = 0; i < 14; i++) begin
            rule_en  = tbl[i].en;
            mgr_addr = tbl[i].addr;
            mgr_req  = tbl[i].req;
            sbr_gnt  = tbl[i].gnt;
            #2;
            chk($sformatf("dec%0d_req", i), sbr_req, tbl[i].exp_req);
            chk($sformatf("dec%0d_gnt", i), mgr_gnt, tbl[i].exp_gnt);
        end
        rule_en = 4'hF;

        // Fill the tracker to MaxTrans on subordinate 1, then release one slot.
        set_rule(0, 32'h1000_0000, 32'h1000_2000, 1, 1'b1);
        set_rule(1, 32'h3000_0000, 32'h3000_1000, 3, 1'b1);
        set_rule(2, 32'h0, 32'h0, 0, 1'b0);
        set_rule(3, 32'h0, 32'h0, 0, 1'b0);
        apply_rules();
        do_reset();
        sbr_gnt = 5'b11110; mgr_req = 1'b1; mgr_addr = 32'h1000_0000;
        for (int i = 0; i < MaxTrans; i++) begin
            @(negedge clk);
            chk($sformatf("fill%0d_gnt", i), mgr_gnt, 1'b1);
            chk($sformatf("fill%0d_req", i), sbr_req, 5'b00010);
            next_cyc();
        end
        @(negedge clk);
        chk("full_gnt", mgr_gnt, 1'b0);
        chk("full_req", sbr_req, 5'b0);
        next_cyc();
        sbr_rvalid = 5'b00010;
        @(negedge clk);
        chk("full_rvalid", mgr_rvalid, 1'b1);
        chk("full_no_bypass", mgr_gnt, 1'b0);
        next_cyc();
        sbr_rvalid = '0;
        @(negedge clk);
        chk("full_regnt", mgr_gnt, 1'b1);
        next_cyc();
        mgr_req = 1'b0; sbr_rvalid = 5'b00010;
        for (int i = 0; i < MaxTrans; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_rvalid", i), mgr_rvalid, 1'b1);
            next_cyc();
        end
        sbr_rvalid = '0;
        @(negedge clk);
        chk("drained_rvalid", mgr_rvalid, 1'b0);
        next_cyc();

        // Target switch waits for outstanding responses; foreign rvalid ignored.
        mgr_req = 1'b1; mgr_addr = 32'h1000_0010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("sw_a%0d_gnt", i), mgr_gnt, 1'b1);
            next_cyc();
        end
        mgr_addr = 32'h3000_0010; sbr_rvalid = 5'b01000;
        @(negedge clk);
        chk("sw_stall_gnt", mgr_gnt, 1'b0);
        chk("sw_stall_req", sbr_req, 5'b0);
        chk("sw_foreign_rvalid", mgr_rvalid, 1'b0);
        next_cyc();
        sbr_rvalid = 5'b00010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("sw_resp%0d_rvalid", i), mgr_rvalid, 1'b1);
            chk($sformatf("sw_resp%0d_gnt", i), mgr_gnt, 1'b0);
            next_cyc();
        end
        sbr_rvalid = '0;
        @(negedge clk);
        chk("sw_go_gnt", mgr_gnt, 1'b1);
        chk("sw_go_req", sbr_req, 5'b01000);
        next_cyc();
        mgr_req = 1'b0; sbr_rvalid = 5'b01000;
        @(negedge clk);
        chk("sw_b_rvalid", mgr_rvalid, 1'b1);
        next_cyc();
        sbr_rvalid = '0;

        // Reset with two transactions outstanding on subordinate 1.
        mgr_req = 1'b1; mgr_addr = 32'h1000_0000;
        next_cyc();
        next_cyc();
        mgr_req = 1'b1; mgr_addr = 32'h3000_0000; sbr_rvalid = 5'b00010; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_gnt", mgr_gnt, 1'b1);
        chk("rst_mid_req", sbr_req, 5'b01000);
        chk("rst_mid_rvalid", mgr_rvalid, 1'b0);
        next_cyc();
        rst = 1'b0; mgr_req = 1'b0;
        @(negedge clk);
        chk("late_rvalid_dropped", mgr_rvalid, 1'b0);
        next_cyc();
        sbr_rvalid = '0;

        // Three unmapped accesses, back to back, answered by the error subordinate.
        do_reset();
        chk("err_cnt_after_rst", err_cnt, 32'd0);
        mgr_addr = 32'h5000_0000;
        for (int i = 0; i < 4; i++) begin
            mgr_req = (i < 3);
            mgr_aid = IW'(i % 2);
            @(negedge clk);
            if (i < 3) chk($sformatf("err%0d_gnt", i), mgr_gnt, 1'b1);
            chk($sformatf("err%0d_sbr_req", i), sbr_req, 5'b0);
            chk($sformatf("err%0d_rvalid", i), mgr_rvalid, i > 0);
            if (i > 0) begin
                chk($sformatf("err%0d_rdata", i), mgr_rdata, 32'hBADCAB1E);
                chk($sformatf("err%0d_err", i), mgr_err, 1'b1);
                chk($sformatf("err%0d_rid", i), mgr_rid, (i - 1) % 2);
            end
            next_cyc();
        end
        @(negedge clk);
        chk("err_idle_rvalid", mgr_rvalid, 1'b0);
        chk("err_cnt_3", err_cnt, StatsEn ? 32'd3 : 32'd0);
        next_cyc();

        // Randomized run against the transaction-queue model.
        do_reset();
        q.delete();
        exp_err = 0;
        pending = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 64 == 0) begin
                for (int r = 0; r < NumRules; r++) begin
                    m_start[r] = 32'h1000_0000 + 32'($urandom_range(0, 2)) * 32'h1000_0000
                               + 32'($urandom_range(0, 'h3000));
                    m_end[r]   = ($urandom_range(0, 5) == 0) ? m_start[r] - 32'h10
                               : m_start[r] + 32'($urandom_range(4, 'h2000));
                    m_idx[r]   = $urandom_range(0, 7);
                    m_en[r]    = ($urandom_range(0, 3) != 0);
                end
                apply_rules();
            end
            if (!pending) begin
                hd = $urandom_range(0, NumRules - 1);
                case ($urandom_range(0, 5))
                    0: a_pick = m_start[hd];
                    1: a_pick = m_end[hd];
                    2: a_pick = m_end[hd] - 32'd4;
                    3: a_pick = m_start[hd] - 32'd4;
                    4: a_pick = m_start[hd] + 32'($urandom_range(0, 'hFFF));
                    default: a_pick = $urandom;
                endcase
                mgr_req   = ($urandom_range(0, 3) != 0);
                mgr_addr  = a_pick;
                mgr_we    = 1'($urandom);
                mgr_be    = 4'($urandom);
                mgr_wdata = $urandom;
                mgr_aid   = IW'($urandom);
            end
            sbr_gnt   = mgr_req ? 5'($urandom) : 5'b0;
            sbr_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom};
            sbr_rid   = 5'($urandom);
            sbr_err   = 5'($urandom);
            sbr_rvalid = '0;
            if (q.size() > 0) begin
                hd = q[0].tgt;
                if (hd != 0 && $urandom_range(0, 2) == 0) sbr_rvalid[hd] = 1'b1;
                for (int s = 1; s < NumSbr; s++)
                    if (s != hd && $urandom_range(0, 7) == 0) sbr_rvalid[s] = 1'b1;
            end
            @(negedge clk);
            e_sel   = model_sel(mgr_addr);
            e_stall = (q.size() == MaxTrans) || (q.size() != 0 && q[0].tgt != e_sel);
            e_req   = '0;
            e_gnt   = 1'b0;
            if (!e_stall) begin
                if (e_sel == 0) e_gnt = mgr_req;
                else begin
                    e_req[e_sel] = mgr_req;
                    e_gnt = sbr_gnt[e_sel];
                end
            end
            e_rv = 1'b0;
            if (q.size() > 0) e_rv = (q[0].tgt == 0) ? 1'b1 : sbr_rvalid[q[0].tgt];
            chk("rnd_gnt", mgr_gnt, e_gnt);
            chk("rnd_req", sbr_req, e_req);
            chk("rnd_rvalid", mgr_rvalid, e_rv);
            chk("rnd_addr", sbr_addr, mgr_addr);
            chk("rnd_err_cnt", err_cnt, StatsEn ? 32'(exp_err) : 32'd0);
            if (e_rv) begin
                if (q[0].tgt == 0) begin
                    chk("rnd_rdata", mgr_rdata, 32'hBADCAB1E);
                    chk("rnd_rid", mgr_rid, q[0].aid);
                    chk("rnd_err", mgr_err, 1'b1);
                end else begin
                    chk("rnd_rdata", mgr_rdata, sbr_rdata[q[0].tgt*DW +: DW]);
                    chk("rnd_rid", mgr_rid, sbr_rid[q[0].tgt]);
                    chk("rnd_err", mgr_err, sbr_err[q[0].tgt]);
                end
            end
            @(posedge clk);
            if (e_rv) begin
                if (q[0].tgt == 0) exp_err++;
                void'(q.pop_front());
            end
            if (mgr_req && e_gnt) q.push_back('{e_sel, mgr_aid[0]});
            pending = mgr_req && !e_gnt;
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
